// File: rtl/decoder_pkg.sv
// Shared definitions for registered_decoder: FSM state encoding and the
// default address width.
package decoder_pkg;

  localparam int ADDR_W_DEFAULT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_core.sv
// Combinational N-to-2^N one-hot decoder; a low enable forces an all-zero result.
module decoder_core #(
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]    address,
  input  logic                 enable,
  output logic [2**ADDR_W-1:0] out
);

  localparam int OUT_W = 2**ADDR_W;

  assign out = enable ? (OUT_W'(1) << address) : '0;

endmodule

// File: rtl/registered_decoder.sv
// Registered one-hot decoder with an optional scan sequence (rotate through all
// lines, then zero). Scan support is built only when REGISTERED_DECODER_SCAN_EN is defined.
module registered_decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 enable,
  input  logic                 mode,
  output logic [2**ADDR_W-1:0] out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int OUT_W = 2**ADDR_W;

  logic [OUT_W-1:0] dec_out;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;

  decoder_core #(
    .ADDR_W (ADDR_W)
  ) u_core (
    .address (address),
    .enable  (enable),
    .out     (dec_out)
  );

`ifdef REGISTERED_DECODER_SCAN_EN

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;

  // Counter holds the number of rotations still to show; the step taken at
  // zero clears the output and releases the requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            out_q       <= dec_out;
            out_valid_q <= 1'b1;
            if (mode && enable) begin
              cnt_q   <= '1;
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          out_valid_q <= 1'b1;
          if (cnt_q == '0) begin
            out_q   <= '0;
            state_q <= IDLE;
          end else begin
            out_q <= {out_q[OUT_W-2:0], out_q[OUT_W-1]};
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SCAN);

`else

  logic unused_mode;
  assign unused_mode = mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q <= dec_out;
      end
    end
  end

  assign in_ready = 1'b1;
  assign busy     = 1'b0;

`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_registered_decoder.sv
// Bench for registered_decoder: three widths (ADDR_W=1,2,3) share one stimulus
// stream; a sequence-list model is compared every cycle, plus literal expectations.
module tb_registered_decoder;

`ifdef REGISTERED_DECODER_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in_valid, enable, mode;
  logic [2:0] addr;

  logic [3:0] outA; logic vldA, rdyA, busyA;
  logic [7:0] outB; logic vldB, rdyB, busyB;
  logic [1:0] outC; logic vldC, rdyC, busyC;

  int  passed = 0;
  int  total  = 0;
  bit  run    = 1'b0;

  always #5 clk = ~clk;

  registered_decoder #(.ADDR_W(2)) dutA (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyA),
    .address(addr[1:0]), .enable(enable), .mode(mode),
    .out(outA), .out_valid(vldA), .busy(busyA));

  registered_decoder #(.ADDR_W(3)) dutB (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyB),
    .address(addr), .enable(enable), .mode(mode),
    .out(outB), .out_valid(vldB), .busy(busyB));

  registered_decoder #(.ADDR_W(1)) dutC (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyC),
    .address(addr[0]), .enable(enable), .mode(mode),
    .out(outC), .out_valid(vldC), .busy(busyC));

  // Model: the visible output plus the list of values a running scan still has
  // to show. Busy means that list is non-empty.
  typedef struct packed {
    logic [3:0]      npend;
    logic [8:0][7:0] pend;
    logic [7:0]      out;
    logic            vld;
  } mdl_t;

  mdl_t mA = '0, mB = '0, mC = '0;

  function automatic mdl_t mstep(mdl_t s, int aw, bit rst, bit iv, int a_in,
                                 bit en, bit md);
    mdl_t r;
    int n, a;
    n = 1 << aw;
    a = a_in % n;
    r = s;
    r.vld = 1'b0;
    if (rst) begin
      r = '0;
      return r;
    end
    if (s.npend != 0) begin
      r.out = s.pend[0];
      for (int i = 0; i < 8; i++) r.pend[i] = s.pend[i+1];
      r.pend[8] = 8'h00;
      r.npend = s.npend - 4'd1;
      r.vld = 1'b1;
    end else if (iv) begin
      r.vld = 1'b1;
      r.out = en ? 8'(1 << a) : 8'h00;
      if (SCAN_EN && md && en) begin
        for (int k = 1; k < n; k++) r.pend[k-1] = 8'(1 << ((a + k) % n));
        r.pend[n-1] = 8'h00;
        r.npend = 4'(n);
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    mA <= mstep(mA, 2, reset, in_valid, int'(addr), enable, mode);
    mB <= mstep(mB, 3, reset, in_valid, int'(addr), enable, mode);
    mC <= mstep(mC, 1, reset, in_valid, int'(addr), enable, mode);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Packed as {out, out_valid, in_ready, busy}.
  always @(negedge clk) begin
    if (run) begin
      chk("cmpA", {4'b0, outA, vldA, rdyA, busyA}, {mA.out, mA.vld, mA.npend == 0, mA.npend != 0});
      chk("cmpB", {outB, vldB, rdyB, busyB},       {mB.out, mB.vld, mB.npend == 0, mB.npend != 0});
      chk("cmpC", {6'b0, outC, vldC, rdyC, busyC}, {mC.out, mC.vld, mC.npend == 0, mC.npend != 0});
    end
  end

  task automatic drive(input bit iv, input int a, input bit en, input bit md);
    in_valid = iv;
    addr     = 3'(a);
    enable   = en;
    mode     = md;
  endtask

  logic [7:0] scan31 [9];

  initial begin
    scan31 = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h00};
    reset = 1'b1;
    drive(1'b1, 1, 1'b1, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("reset_state", {outA, vldA, rdyA, busyA}, {4'b0000, 1'b0, 1'b1, 1'b0});
    chk("reset_model", {mA.out, mA.vld}, 9'h000);
    run   = 1'b1;
    reset = 1'b0;

    // Direct decode of address 2 then 0.
    drive(1'b1, 2, 1'b1, 1'b0);
    @(negedge clk);
    chk("direct_a2", {outA, vldA}, {4'b0100, 1'b1});
    chk("direct_a2_model", mA.out, 8'h04);
    drive(1'b1, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("direct_a0", {outA, vldA}, {4'b0001, 1'b1});
    drive(1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_no_pulse", {outA, vldA}, {4'b0001, 1'b0});

    // Disabled accept clears the output, then holds.
    drive(1'b1, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("disabled", {outA, vldA}, {4'b0000, 1'b1});
    drive(1'b0, 3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("disabled_hold", {outA, vldA}, {4'b0000, 1'b0});

    // Disabled scan request behaves as a disabled direct accept.
    drive(1'b1, 2, 1'b0, 1'b1);
    @(negedge clk);
    chk("scan_dis", {outA, vldA, busyA, rdyA}, {4'b0000, 1'b1, 1'b0, 1'b1});
    drive(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);

    // Scan from address 6 on the 8-line decoder; the 2-line one scans from 0.
    drive(1'b1, 6, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (SCAN_EN) begin
        chk("scan8_out", {outB, vldB}, {scan31[k], 1'b1});
        chk("scan8_busy", {busyB, rdyB}, {k < 8, k >= 8});
        chk("scan8_model", mB.out, scan31[k]);
        if (k < 3) chk("scan2_out", outC, (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b00);
      end else if (k == 0) begin
        chk("noscan_b", {outB, vldB, busyB, rdyB}, {8'h40, 1'b1, 1'b0, 1'b1});
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Request held during a scan is taken only once the scan returns to idle.
    drive(1'b1, 0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (SCAN_EN) begin
        if (k >= 1 && k <= 3) chk("held_ignored", rdyA, 1'b0);
        if (k == 4) chk("scan_end", {outA, rdyA, busyA}, {4'b0000, 1'b1, 1'b0});
        if (k == 5) chk("held_taken", {outA, vldA}, {4'b0010, 1'b1});
      end else if (k == 1) begin
        chk("mode_ignored", {outA, busyA, rdyA}, {4'b0010, 1'b0, 1'b1});
      end
      @(negedge clk);
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);

    // Reset during the third scan cycle aborts the scan.
    drive(1'b1, 0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_abort", {outA, vldA, busyA, rdyA}, {4'b0000, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_abort", {outA, vldA}, {4'b0000, 1'b0});

    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
